memory_arbiter: RTL and testbench

//  Two-port round-robin arbiter and sequencer for the 8-byte memory array. Accepts

---
 rtl/mem_pkg.sv | 18 +
 rtl/rr_arbiter2.sv | 41 ++++
 rtl/memory_arbiter.sv | 138 +++++++++++++
 tb/tb_memory_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory arbiter, array and drivers.
// FSM state encoding and read/write op constants.
package mem_pkg;

    localparam int MEM_ADDR_W = 3;
    localparam int MEM_DATA_W = 8;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant with pointer update on accept.
// Pointer names the favoured requester when both are valid.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic ptr_q;
    logic ptr_d;

    // Grant the pointer side on a tie, else the lone requester
    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                grant[ptr_q] = 1'b1;
            end else begin
                grant = req;
            end
        end
        ptr_d = ptr_q;
        if (grant[0]) begin
            ptr_d = 1'b1;
        end else if (grant[1]) begin
            ptr_d = 1'b0;
        end
    end

    // Pointer register, requester 0 favoured after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter and sequencer for the single-port memory array.
// One transaction in flight: accept, issue strobe, wait read latency, respond.
module memory_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic                i_clock,
    input  logic                i_reset_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0]          req_rw,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          rsp_valid,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                mem_valid,
    output logic                mem_rw,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    state_e              state_q, state_d;
    logic                id_q, id_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                mem_valid_q, mem_valid_d;
    logic                mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [1:0]          rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [1:0]          gnt;
    logic                arb_en;

    // Accepts only while idle; held off while reset is asserted
    assign arb_en = (state_q == IDLE) && i_reset_n;

    rr_arbiter2 u_rr (
        .clk   (i_clock),
        .rst_n (i_reset_n),
        .en    (arb_en),
        .req   (req_valid),
        .grant (gnt)
    );

    assign req_ready = gnt;
    assign mem_valid = mem_valid_q;
    assign mem_rw    = mem_rw_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != IDLE);

    // Next-state, payload latch, latency count and response data
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        mem_valid_d = 1'b0;
        mem_rw_d    = mem_rw_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = 2'b00;
        rsp_data_d  = '0;
        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    id_d        = gnt[1];
                    mem_valid_d = 1'b1;
                    mem_rw_d    = req_rw[gnt[1]];
                    mem_addr_d  = gnt[1] ? req_addr[ADDR_W +: ADDR_W]
                                         : req_addr[0 +: ADDR_W];
                    mem_wdata_d = gnt[1] ? req_wdata[DATA_W +: DATA_W]
                                         : req_wdata[0 +: DATA_W];
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_rw_q == RW_WRITE) begin
                    rdata_d = '0;
                    state_d = RESP;
                end else begin
                    cnt_d   = 3'(RD_LAT - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    rdata_d = mem_rdata;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                rsp_valid_d[id_q] = 1'b1;
                rsp_data_d        = rdata_q;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any in-flight access
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= IDLE;
            id_q        <= 1'b0;
            cnt_q       <= 3'd0;
            rdata_q     <= '0;
            mem_valid_q <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 2'b00;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            mem_valid_q <= mem_valid_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed table, corner sequences,
// contention and random traffic against a transaction-level model.
module tb_memory_arbiter;
    import mem_pkg::*;

    localparam int AW   = 3;
    localparam int DW   = 8;
    localparam int LAT1 = 1;
    localparam int LAT4 = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      req_valid = 2'b00;
    logic [1:0]      req_valid4 = 2'b00;
    logic [1:0]      req_rw = 2'b00;
    logic [2*AW-1:0] req_addr = '0;
    logic [2*DW-1:0] req_wdata = '0;

    logic [1:0]    req_ready, rsp_valid, req_ready4, rsp_valid4;
    logic [DW-1:0] rsp_data, rsp_data4;
    logic          mem_valid, mem_rw, busy, mem_valid4, mem_rw4, busy4;
    logic [AW-1:0] mem_addr, mem_addr4;
    logic [DW-1:0] mem_wdata, mem_rdata, mem_wdata4, mem_rdata4;

    memory_arbiter #(.RD_LAT(LAT1)) u_dut (
        .i_clock(clk), .i_reset_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    memory_arbiter #(.RD_LAT(LAT4)) u_dut4 (
        .i_clock(clk), .i_reset_n(rst_n),
        .req_valid(req_valid4), .req_ready(req_ready4),
        .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid4), .rsp_data(rsp_data4),
        .mem_valid(mem_valid4), .mem_rw(mem_rw4), .mem_addr(mem_addr4),
        .mem_wdata(mem_wdata4), .mem_rdata(mem_rdata4), .busy(busy4)
    );

    // Memory array models: contents i*0x11, reads return 0xEE when not valid
    logic [DW-1:0] marr1 [8];
    logic [DW-1:0] pipe1 [LAT1];
    logic [DW-1:0] marr4 [8];
    logic [DW-1:0] pipe4 [LAT4];
    bit minit = 1'b0;

    always @(posedge clk) begin
        if (!minit) begin
            for (int i = 0; i < 8; i++) begin
                marr1[i] <= 8'(i * 17);
                marr4[i] <= 8'(i * 17);
            end
            for (int i = 0; i < LAT1; i++) pipe1[i] <= 8'hEE;
            for (int i = 0; i < LAT4; i++) pipe4[i] <= 8'hEE;
            minit <= 1'b1;
        end else begin
            for (int i = LAT1 - 1; i > 0; i--) pipe1[i] <= pipe1[i-1];
            pipe1[0] <= (mem_valid && !mem_rw) ? marr1[mem_addr] : 8'hEE;
            if (mem_valid && mem_rw) marr1[mem_addr] <= mem_wdata;
            for (int i = LAT4 - 1; i > 0; i--) pipe4[i] <= pipe4[i-1];
            pipe4[0] <= (mem_valid4 && !mem_rw4) ? marr4[mem_addr4] : 8'hEE;
            if (mem_valid4 && mem_rw4) marr4[mem_addr4] <= mem_wdata4;
        end
    end
    assign mem_rdata  = pipe1[LAT1-1];
    assign mem_rdata4 = pipe4[LAT4-1];

    int checks = 0;
    int failures = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one access at a time, busy for a fixed span
    int        cyc = 0;
    int        acc_at = -100;
    int        mem_at = -1;
    int        due = -1;
    bit        ptr_m = 1'b0;
    logic [DW-1:0] sb [8];
    bit        m_id, m_rw;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_exp;
    logic [1:0] acc_flag;
    int        obs_cyc = -1;
    bit        obs_id;
    logic [DW-1:0] obs_data;
    int        rsp_n [2];
    int        mem_n = 0;
    bit        grants [$];

    task automatic step();
        logic [1:0] eg;
        @(negedge clk);
        cyc++;
        acc_flag = 2'b00;
        if (!rst_n) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_mem_valid", mem_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_mem_bus", {mem_rw, mem_addr, mem_wdata, rsp_data}, 0);
            acc_at = -100;
            mem_at = -1;
            due = -1;
            ptr_m = 1'b0;
        end else begin
            eg = 2'b00;
            if (cyc >= due) begin
                if (req_valid == 2'b11) eg = ptr_m ? 2'b10 : 2'b01;
                else eg = req_valid;
            end
            chk("req_ready", req_ready, eg);
            chk("mem_valid", mem_valid, cyc == mem_at);
            if (cyc == mem_at) begin
                chk("mem_rw", mem_rw, m_rw);
                chk("mem_addr", mem_addr, m_addr);
                if (m_rw) chk("mem_wdata", mem_wdata, m_wdata);
            end
            chk("busy", busy, (cyc > acc_at) && (cyc < due));
            chk("rsp_valid", rsp_valid, (cyc == due) ? (2'b01 << m_id) : 2'b00);
            if (cyc == due) chk("rsp_data", rsp_data, m_exp);
            if (mem_valid) mem_n++;
            if (rsp_valid != 2'b00) begin
                obs_cyc = cyc;
                obs_id = rsp_valid[1];
                obs_data = rsp_data;
                rsp_n[rsp_valid[1]]++;
            end
            if (eg != 2'b00) begin
                m_id = eg[1];
                m_rw = req_rw[m_id];
                m_addr = req_addr[int'(m_id)*AW +: AW];
                m_wdata = req_wdata[int'(m_id)*DW +: DW];
                acc_at = cyc;
                mem_at = cyc + 1;
                due = cyc + 3 + (m_rw ? 0 : LAT1);
                m_exp = m_rw ? 8'h00 : sb[m_addr];
                if (m_rw) sb[m_addr] = m_wdata;
                ptr_m = ~m_id;
                grants.push_back(m_id);
                acc_flag = eg;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(bit id, bit rw, logic [AW-1:0] a, logic [DW-1:0] d);
        req_rw[id] = rw;
        req_addr[int'(id)*AW +: AW] = a;
        req_wdata[int'(id)*DW +: DW] = d;
    endtask

    task automatic set_rand(bit id);
        set_req(id, 1'($urandom), 3'($urandom), 8'($urandom));
    endtask

    // One request on the RD_LAT=1 instance; latency measured from observed edges
    task automatic txn(input bit id, input bit rw, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output int lat,
                       output logic [DW-1:0] rd, output bit rid);
        bit got = 1'b0;
        int a_cyc = 0;
        set_req(id, rw, a, d);
        req_valid[id] = 1'b1;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (acc_flag[id]) begin
                got = 1'b1;
                a_cyc = cyc;
            end
        end
        chk("txn_accept_seen", got, 1);
        req_valid[id] = 1'b0;
        obs_cyc = -1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (obs_cyc >= 0) got = 1'b1;
        end
        chk("txn_rsp_seen", got, 1);
        lat = got ? (obs_cyc - a_cyc - 1) : -1;
        rd = obs_data;
        rid = obs_id;
    endtask

    // One request on the RD_LAT=4 instance
    task automatic run4(input bit id, input bit rw, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int lat,
                        output logic [DW-1:0] rd, output logic [1:0] rv);
        bit got = 1'b0;
        int t = 0;
        int a_t = 0;
        set_req(id, rw, a, d);
        req_valid4[id] = 1'b1;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            t++;
            if (req_ready4[id]) begin
                got = 1'b1;
                a_t = t;
            end
            @(posedge clk);
            #1;
        end
        chk("run4_accept_seen", got, 1);
        req_valid4[id] = 1'b0;
        got = 1'b0;
        lat = -1;
        rd = '0;
        rv = '0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            t++;
            if (rsp_valid4 != 2'b00) begin
                got = 1'b1;
                lat = t - a_t - 1;
                rd = rsp_data4;
                rv = rsp_valid4;
            end
        end
        chk("run4_rsp_seen", got, 1);
    endtask

    typedef struct {
        bit            id;
        bit            rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_data;
        int            exp_lat;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int lat;
        logic [DW-1:0] rd;
        bit rid;
        logic [1:0] rv;
        int n_acc [2];
        int a0, a1, rsp_before;
        bit got;

        for (int i = 0; i < 8; i++) sb[i] = 8'(i * 17);
        rsp_n[0] = 0;
        rsp_n[1] = 0;

        tbl[0] = '{1'b0, 1'b1, 3'd3, 8'hA5, 8'h00, 2};
        tbl[1] = '{1'b1, 1'b0, 3'd3, 8'h00, 8'hA5, 3};
        tbl[2] = '{1'b1, 1'b1, 3'd7, 8'h3C, 8'h00, 2};
        tbl[3] = '{1'b0, 1'b0, 3'd7, 8'h00, 8'h3C, 3};
        tbl[4] = '{1'b0, 1'b0, 3'd5, 8'h00, 8'h55, 3};
        tbl[5] = '{1'b1, 1'b1, 3'd0, 8'hFF, 8'h00, 2};
        tbl[6] = '{1'b1, 1'b0, 3'd0, 8'h00, 8'hFF, 3};
        tbl[7] = '{1'b0, 1'b0, 3'd6, 8'h00, 8'h66, 3};

        // Reset held: outputs zero even with requests pending
        step();
        req_valid = 2'b11;
        step();
        req_valid = 2'b00;
        step();
        rst_n = 1'b1;
        step();

        // Directed single transactions
        for (int i = 0; i < 8; i++) begin
            txn(tbl[i].id, tbl[i].rw, tbl[i].addr, tbl[i].wdata, lat, rd, rid);
            chk($sformatf("tbl%0d_lat", i), lat, tbl[i].exp_lat);
            chk($sformatf("tbl%0d_data", i), rd, tbl[i].exp_data);
            chk($sformatf("tbl%0d_id", i), rid, tbl[i].id);
        end

        // Late arrival: req1 raised while req0 read is in flight
        set_req(1'b0, RW_READ, 3'd4, 8'h00);
        req_valid[0] = 1'b1;
        got = 1'b0;
        a0 = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (acc_flag[0]) begin
                got = 1'b1;
                a0 = cyc;
            end
        end
        chk("late_req0_accept", got, 1);
        req_valid[0] = 1'b0;
        step();
        set_req(1'b1, RW_READ, 3'd3, 8'h00);
        req_valid[1] = 1'b1;
        got = 1'b0;
        a1 = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (acc_flag[1]) begin
                got = 1'b1;
                a1 = cyc;
            end
        end
        chk("late_req1_accept", got, 1);
        chk("late_req1_cycle", a1, a0 + 3 + LAT1);
        req_valid[1] = 1'b0;
        obs_cyc = -1;
        for (int i = 0; i < 10 && obs_cyc < 0; i++) step();
        chk("late_req1_rsp_id", obs_id, 1);
        chk("late_req1_rsp_data", obs_data, 8'hA5);

        // Reset while waiting on read data: no response afterwards
        set_req(1'b0, RW_READ, 3'd5, 8'h00);
        req_valid[0] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (acc_flag[0]) got = 1'b1;
        end
        chk("rstwait_accept", got, 1);
        req_valid[0] = 1'b0;
        step();
        rsp_before = rsp_n[0] + rsp_n[1];
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (4) step();
        chk("rstwait_no_rsp", rsp_n[0] + rsp_n[1], rsp_before);

        // Contention: pointer back at 0, grants must alternate from 0
        grants.delete();
        mem_n = 0;
        rsp_n[0] = 0;
        rsp_n[1] = 0;
        n_acc[0] = 0;
        n_acc[1] = 0;
        set_rand(1'b0);
        set_rand(1'b1);
        req_valid = 2'b11;
        for (int i = 0; i < 200 && (rsp_n[0] + rsp_n[1]) < 16; i++) begin
            step();
            for (int k = 0; k < 2; k++) begin
                if (acc_flag[k]) begin
                    n_acc[k]++;
                    if (n_acc[k] < 8) set_rand(1'(k));
                    else req_valid[k] = 1'b0;
                end
            end
        end
        chk("cont_grant_count", grants.size(), 16);
        for (int i = 0; i < grants.size() && i < 16; i++) begin
            chk($sformatf("cont_grant%0d", i), grants[i], i % 2);
        end
        chk("cont_mem_strobes", mem_n, 16);
        chk("cont_rsp0", rsp_n[0], 8);
        chk("cont_rsp1", rsp_n[1], 8);

        // Longer read latency instance
        run4(1'b0, RW_WRITE, 3'd2, 8'h5A, lat, rd, rv);
        chk("lat4_wr_lat", lat, 2);
        chk("lat4_wr_data", rd, 8'h00);
        chk("lat4_wr_id", rv, 2'b01);
        run4(1'b1, RW_READ, 3'd2, 8'h00, lat, rd, rv);
        chk("lat4_rd_lat", lat, 6);
        chk("lat4_rd_data", rd, 8'h5A);
        chk("lat4_rd_id", rv, 2'b10);

        // Random traffic against the model
        rsp_n[0] = 0;
        rsp_n[1] = 0;
        for (int i = 0; i < 400; i++) begin
            step();
            for (int k = 0; k < 2; k++) begin
                if (acc_flag[k]) req_valid[k] = 1'b0;
                if (!req_valid[k] && $urandom_range(0, 2) == 0) begin
                    set_rand(1'(k));
                    req_valid[k] = 1'b1;
                end
            end
        end
        req_valid = 2'b00;
        repeat (10) step();
        chk("rand_activity", (rsp_n[0] > 10) && (rsp_n[1] > 10), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
